// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage with an IF/ID pipeline register, a one-entry skid
//   buffer for words that complete while ID is stalled, and a pending-redirect
//   register for branches that resolve while a fetch is still outstanding.
//   The word completing at or after branch acceptance is the delay slot and
//   is always delivered to ID.
//
// Ports
//   clk         : sole clock, rising edge
//   rst_n       : synchronous active-low reset
//   stall       : ID hold request (1 = IF/ID register must not change)
//   isbranch    : taken branch/jump resolved by the instruction in ID
//   branch_pc   : redirect target (byte address, low two bits ignored)
//   imem_req    : fetch request, high only while fetching
//   imem_addr   : fetch address (always the current PC, word aligned)
//   imem_ready  : imem_rdata is valid for the current request this cycle
//   imem_rdata  : fetched instruction word
//   id_pc       : PC of the instruction in the IF/ID register
//   id_inst     : instruction word in the IF/ID register
//   id_valid    : IF/ID register holds a real instruction (0 = bubble)
// -----------------------------------------------------------------------------
module fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        isbranch,
  input  logic [31:0] branch_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;

  logic        redir_acc;
  logic [31:0] tgt_aligned;

  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc_q;
  assign id_pc     = id_pc_q;
  assign id_inst   = id_inst_q;
  assign id_valid  = id_valid_q;

  // A branch only counts when a real instruction sits in ID and ID advances.
  assign redir_acc   = isbranch && id_valid_q && !stall;
  assign tgt_aligned = {branch_pc[31:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_inst_d = buf_inst_q;
    buf_pc_d   = buf_pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        if (imem_ready) begin
          // This word is the delay slot if a redirect is live; keep it and
          // steer the next fetch to the target.
          if (redir_acc) begin
            pc_d = tgt_aligned;
          end else if (pend_q) begin
            pc_d = pend_tgt_q;
          end else begin
            pc_d = pc_q + 32'd4;
          end
          pend_d = 1'b0;
          if (!stall) begin
            id_inst_d  = imem_rdata;
            id_pc_d    = pc_q;
            id_valid_d = 1'b1;
          end else begin
            buf_inst_d = imem_rdata;
            buf_pc_d   = pc_q;
            state_d    = HOLD;
          end
        end else begin
          // Outstanding fetch address must not move; remember the target.
          if (redir_acc) begin
            pend_d     = 1'b1;
            pend_tgt_d = tgt_aligned;
          end
          if (!stall) begin
            id_valid_d = 1'b0;
          end
        end
      end

      HOLD: begin
        if (!stall) begin
          id_inst_d  = buf_inst_q;
          id_pc_d    = buf_pc_q;
          id_valid_d = 1'b1;
          state_d    = FETCH;
          // No fetch is outstanding here, so the target applies directly.
          if (redir_acc) begin
            pc_d = tgt_aligned;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= 32'd0;
      buf_inst_q <= 32'd0;
      buf_pc_q   <= 32'd0;
      pend_q     <= 1'b0;
      pend_tgt_q <= 32'd0;
      id_pc_q    <= 32'd0;
      id_inst_q  <= 32'd0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_inst_q <= buf_inst_d;
      buf_pc_q   <= buf_pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        isbranch;
  logic [31:0] branch_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .isbranch   (isbranch),
    .branch_pc  (branch_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .id_pc      (id_pc),
    .id_inst    (id_inst),
    .id_valid   (id_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        st;
    logic        br;
    logic [31:0] bpc;
    logic        rdy;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ipc;
    logic [31:0] iinst;
  } vec_t;

  vec_t vecs[$];

  // Instruction word stored at a given address.
  function automatic logic [31:0] w(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  function automatic vec_t mk(input logic st, input logic br, input logic [31:0] bpc,
                              input logic rdy, input logic [31:0] rdata,
                              input logic req, input logic [31:0] addr,
                              input logic vld, input logic [31:0] ipc,
                              input logic [31:0] iinst);
    vec_t v;
    v.st = st; v.br = br; v.bpc = bpc; v.rdy = rdy; v.rdata = rdata;
    v.req = req; v.addr = addr; v.vld = vld; v.ipc = ipc; v.iinst = iinst;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic req, input logic [31:0] addr,
                         input logic vld, input logic [31:0] ipc, input logic [31:0] iinst);
    chk({tag, ".imem_req"},  {31'd0, imem_req}, {31'd0, req});
    chk({tag, ".imem_addr"}, imem_addr, addr);
    chk({tag, ".id_valid"},  {31'd0, id_valid}, {31'd0, vld});
    chk({tag, ".id_pc"},     id_pc, ipc);
    chk({tag, ".id_inst"},   id_inst, iinst);
  endtask

  task automatic drive(input logic st, input logic br, input logic [31:0] bpc,
                       input logic rdy, input logic [31:0] rdata);
    stall = st; isbranch = br; branch_pc = bpc; imem_ready = rdy; imem_rdata = rdata;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF);

    //         st br bpc            rdy rdata           req addr           vld ipc            iinst
    vecs.push_back(mk(0, 0, 32'h0,          1, w(32'h0),   0, 32'h0,          0, 32'h0,          32'h0));
    vecs.push_back(mk(0, 0, 32'h0,          1, w(32'h0),   1, 32'h0,          0, 32'h0,          32'h0));
    vecs.push_back(mk(0, 0, 32'h0,          1, w(32'h4),   1, 32'h4,          1, 32'h0,          w(32'h0)));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,      1, 32'h8,          1, 32'h4,          w(32'h4)));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,      1, 32'h8,          0, 32'h4,          w(32'h4)));
    vecs.push_back(mk(0, 0, 32'h0,          1, w(32'h8),   1, 32'h8,          0, 32'h4,          w(32'h4)));
    vecs.push_back(mk(0, 0, 32'h0,          1, w(32'hC),   1, 32'hC,          1, 32'h8,          w(32'h8)));
    vecs.push_back(mk(1, 0, 32'h0,          1, w(32'h10),  1, 32'h10,         1, 32'hC,          w(32'hC)));
    vecs.push_back(mk(1, 0, 32'h0,          1, 32'h0,      0, 32'h14,         1, 32'hC,          w(32'hC)));
    vecs.push_back(mk(1, 0, 32'h0,          1, 32'h0,      0, 32'h14,         1, 32'hC,          w(32'hC)));
    vecs.push_back(mk(0, 0, 32'h0,          1, 32'h0,      0, 32'h14,         1, 32'hC,          w(32'hC)));
    vecs.push_back(mk(0, 0, 32'h0,          1, w(32'h14),  1, 32'h14,         1, 32'h10,         w(32'h10)));
    vecs.push_back(mk(0, 0, 32'h0,          1, w(32'h18),  1, 32'h18,         1, 32'h14,         w(32'h14)));
    vecs.push_back(mk(0, 0, 32'h0,          1, w(32'h1C),  1, 32'h1C,         1, 32'h18,         w(32'h18)));
    vecs.push_back(mk(0, 0, 32'h0,          1, w(32'h20),  1, 32'h20,         1, 32'h1C,         w(32'h1C)));
    vecs.push_back(mk(0, 1, 32'h100,        1, w(32'h24),  1, 32'h24,         1, 32'h20,         w(32'h20)));
    vecs.push_back(mk(0, 0, 32'h0,          1, w(32'h100), 1, 32'h100,        1, 32'h24,         w(32'h24)));
    vecs.push_back(mk(0, 0, 32'h0,          1, w(32'h104), 1, 32'h104,        1, 32'h100,        w(32'h100)));
    vecs.push_back(mk(0, 1, 32'h203,        0, 32'h0,      1, 32'h108,        1, 32'h104,        w(32'h104)));
    vecs.push_back(mk(0, 1, 32'h300,        0, 32'h0,      1, 32'h108,        0, 32'h104,        w(32'h104)));
    vecs.push_back(mk(0, 0, 32'h0,          1, w(32'h108), 1, 32'h108,        0, 32'h104,        w(32'h104)));
    vecs.push_back(mk(0, 0, 32'h0,          1, w(32'h200), 1, 32'h200,        1, 32'h108,        w(32'h108)));
    vecs.push_back(mk(1, 1, 32'h400,        1, w(32'h204), 1, 32'h204,        1, 32'h200,        w(32'h200)));
    vecs.push_back(mk(1, 1, 32'h400,        1, 32'h0,      0, 32'h208,        1, 32'h200,        w(32'h200)));
    vecs.push_back(mk(0, 1, 32'h400,        1, 32'h0,      0, 32'h208,        1, 32'h200,        w(32'h200)));
    vecs.push_back(mk(0, 0, 32'h0,          1, w(32'h400), 1, 32'h400,        1, 32'h204,        w(32'h204)));
    vecs.push_back(mk(1, 0, 32'h0,          0, 32'h0,      1, 32'h404,        1, 32'h400,        w(32'h400)));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,      1, 32'h404,        1, 32'h400,        w(32'h400)));
    vecs.push_back(mk(0, 0, 32'h0,          1, w(32'h404), 1, 32'h404,        0, 32'h400,        w(32'h400)));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFF,  1, w(32'h408), 1, 32'h408,        1, 32'h404,        w(32'h404)));
    vecs.push_back(mk(0, 0, 32'h0,          1, w(32'hFFFF_FFFC), 1, 32'hFFFF_FFFC, 1, 32'h408,   w(32'h408)));
    vecs.push_back(mk(0, 0, 32'h0,          1, w(32'h0),   1, 32'h0,          1, 32'hFFFF_FFFC,  w(32'hFFFF_FFFC)));
    vecs.push_back(mk(0, 0, 32'h0,          0, 32'h0,      1, 32'h4,          1, 32'h0,          w(32'h0)));

    // Reset state
    step();
    step();
    chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;

    // Main vector table
    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].br, vecs[i].bpc, vecs[i].rdy, vecs[i].rdata);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].vld,
              vecs[i].ipc, vecs[i].iinst);
      step();
    end

    // Reset during an outstanding fetch (FETCH at 0x4, ready low)
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b0;
    step();
    chk_all("rst_fetch", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    #1;
    chk_all("rst_fetch_idle", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    step();
    chk_all("rst_fetch_restart", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    // Reset while a word sits in the skid buffer
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'hBAD0_0000);
    step();
    chk_all("hold_before_rst", 1'b0, 32'h4, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    step();
    chk_all("rst_hold", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b1, w(32'h0));
    step();
    chk_all("rst_hold_idle_exit", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step();
    chk_all("rst_hold_refetch", 1'b1, 32'h4, 1'b1, 32'h0, w(32'h0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on rising clk only.
REQ-003 SHALL have port stall, input, 1, ID stage hold from hazard logic; 1 = ID register must not change.
REQ-004 SHALL have port isbranch, input, 1, taken branch/jump resolved by the instruction currently in ID.
REQ-005 SHALL have port branch_pc, input, 32, redirect target, imem-relative byte address.
REQ-006 SHALL have port imem_req, output, 1, fetch request to instruction memory.
REQ-007 SHALL have port imem_addr, output, 32, fetch address, imem-relative byte address, bits[1:0]=00.
REQ-008 SHALL have port imem_ready, input, 1, imem returns imem_rdata for the current request this cycle.
REQ-009 SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-010 SHALL have ports id_pc (32), id_inst (32), id_valid (1), outputs, the IF/ID register feeding ID.

Function
REQ-011 SHALL hold pc_q (32 b, next fetch address), buf_inst and buf_pc (one-entry skid buffer), and a pending-redirect flag with its 32 b target.
REQ-012 SHALL implement states IDLE, FETCH, HOLD; imem_req=1 only in FETCH; imem_addr=pc_q at all times.
REQ-013 SHALL transition IDLE->FETCH unconditionally on the first cycle after reset release.
REQ-014 SHALL keep imem_req and imem_addr stable in FETCH until imem_ready=1 (fetch completion).
REQ-015 On completion with stall=0: SHALL load id_inst<=imem_rdata, id_pc<=pc_q, id_valid<=1, and remain in FETCH.
REQ-016 On completion with stall=1: SHALL load buf_inst/buf_pc, leave ID register unchanged, and go to HOLD.
REQ-017 In FETCH with imem_ready=0: stall=0 SHALL load id_valid<=0 (bubble); stall=1 SHALL hold the ID register.
REQ-018 In HOLD with stall=0: SHALL move the buffer to ID (id_valid<=1) and go to FETCH; stall=1 holds everything.
REQ-019 On every completion, pc_q SHALL become the redirect target if a redirect is pending or accepted in that cycle, else pc_q+4; the pending flag then clears.
REQ-020 A redirect SHALL be accepted only when isbranch=1, id_valid=1, and stall=0; it is ignored otherwise.
REQ-021 Delay slot: the word completing in FETCH on or after redirect acceptance, or already held in HOLD, SHALL be kept as the delay slot and delivered to ID, never discarded.
REQ-022 Redirect accepted in FETCH with no completion that cycle SHALL set the pending flag and target; the outstanding fetch address is unchanged.
REQ-023 Redirect accepted in HOLD SHALL load pc_q<=target directly; the buffer still drains to ID that cycle.
REQ-024 pc_q SHALL be forced word-aligned: bits[1:0] of the target are cleared; pc_q+4 wraps modulo 2^32.

Reset
REQ-025 While rst_n=0 at a rising edge: SHALL set state=IDLE, pc_q=0, id_pc=0, id_inst=0, id_valid=0, buffer=0, pending=0, target=0.
REQ-026 Reset asserted mid-fetch or in HOLD SHALL abandon the fetch and buffer; imem_req=0 in the cycle after the reset edge.

Verification
REQ-027 Reset, imem_ready tied 1, stall=0 -> first cycle after release imem_req=0; then imem_addr 0,4,8...; id_pc follows one cycle later, id_valid=1.
REQ-028 imem_ready low 2 cycles at addr 0x8 -> imem_addr held at 0x8; id_valid=0 for 2 cycles; then id_inst=rdata, id_pc=0x8.
REQ-029 Completion at 0x10 with stall=1 for 3 cycles -> HOLD, imem_req=0, ID unchanged; stall drops -> id_pc=0x10, fetch resumes at 0x14.
REQ-030 Branch at 0x20 in ID, isbranch=1, branch_pc=0x100, delay slot 0x24 completes the same cycle -> id_pc=0x24 next, following imem_addr=0x100.
REQ-031 Same branch, imem_ready=0 for 2 cycles at 0x24 -> pending set; 0x24 delivered; then imem_addr=0x100, not 0x28.
REQ-032 isbranch=1 with stall=1 for 2 cycles -> no redirect; accepted once stall=0 (HOLD case) -> pc_q=0x100, buffered 0x24 reaches ID.
